// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin / select multiplexer:
// mode encodings and the default channel geometry.
package rr_mux_pkg;

    // Arbitration mode: explicit channel select or fair round-robin.
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_NCH   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational grant logic. In select mode the chosen channel wins
// if it is requesting; in round-robin mode the search starts one past the
// last served channel and wraps, so every requester is served in turn.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NCH = DEFAULT_NCH,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  last,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [NCH-1:0] grant,
    output logic [SW-1:0]  idx,
    output logic           any
);

    logic [SW-1:0] w_cand;

    // Pick at most one channel and report it both one-hot and as an index.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        if (mode == MODE_SEL) begin
            if (int'(sel) < NCH) begin
                if (req[sel]) begin
                    grant[sel] = 1'b1;
                    idx        = sel;
                    any        = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                w_cand = SW'((int'(last) + k) % NCH);
                if (!any && req[w_cand]) begin
                    grant[w_cand] = 1'b1;
                    idx           = w_cand;
                    any           = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// Multiplexes NCH request channels onto one registered output stage.
// The output register reloads whenever it is empty or being drained, so a
// continuous stream moves one word per cycle; the arbiter decides who fills it.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH,
    parameter int SW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SW-1:0]        out_sel,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_outData;
    logic             r_outValid;
    logic [SW-1:0]    r_outSel;
    logic [SW-1:0]    r_last;

    logic             w_loadEn;
    logic [NCH-1:0]   w_grant;
    logic [SW-1:0]    w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_word;

    rr_arbiter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_arbiter (
        .req   (in_valid),
        .last  (r_last),
        .mode  (mode),
        .sel   (sel),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_loadEn = !r_outValid || out_ready;
    assign w_word   = in_data[int'(w_idx)*WIDTH +: WIDTH];
    assign in_ready = (rst || !w_loadEn) ? '0 : w_grant;

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_sel   = r_outSel;

    // Output stage and round-robin pointer; the pointer only moves when a word is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outSel   <= '0;
            r_last     <= SW'(NCH - 1);
        end else if (w_loadEn) begin
            if (w_any) begin
                r_outData  <= w_word;
                r_outSel   <= w_idx;
                r_outValid <= 1'b1;
                r_last     <= w_idx;
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter WIDTH, default 5: data width per channel.
REQ-002 Parameter NCH, default 4: number of input channels, range 2..16.
REQ-003 Parameter SW, default $clog2(NCH): select/channel-index width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel request.
REQ-008 in_ready  output  NCH  per-channel accept; combinational.
REQ-009 mode  input  1  0 = MODE_SEL (explicit select), 1 = MODE_RR (round-robin).
REQ-010 sel  input  SW  channel index used in MODE_SEL.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_sel  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-015 Output register SHALL be loadable when load_en = !out_valid || out_ready.
REQ-016 At most one channel SHALL be granted per cycle; in_ready[i] = load_en && grant[i].
REQ-017 MODE_SEL: grant[sel] = in_valid[sel]; no grant if sel >= NCH.
REQ-018 MODE_RR: grant the first valid channel searching from (last+1) mod NCH upward, wrapping; no grant if in_valid == 0.
REQ-019 Pointer "last" SHALL update to the granted index only on a transfer (in_valid[i] && in_ready[i]); unchanged otherwise, including in MODE_SEL.
REQ-020 On transfer: out_data <= channel word, out_sel <= index, out_valid <= 1 next cycle (latency 1).
REQ-021 load_en with no grant: out_valid <= 0; out_data and out_sel hold.
REQ-022 !load_en (out_valid && !out_ready): out_data, out_sel, out_valid SHALL hold; all in_ready = 0.
REQ-023 Simultaneous out_ready and new grant: old word leaves and new word loads in the same edge; full throughput of one word per cycle.
REQ-024 mode or sel change takes effect in the same cycle's arbitration; a held output word is unaffected.
REQ-025 in_ready SHALL NOT depend on in_valid of non-granted channels beyond the arbitration search.

Reset
REQ-026 During rst: out_valid = 0, out_data = 0, out_sel = 0, last = NCH-1 (channel 0 wins first RR arbitration).
REQ-027 Reset asserted mid-operation SHALL discard any held word immediately (asynchronous); in_ready = 0 while rst is high.
REQ-028 First transfer possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package rr_mux_pkg SHALL hold MODE_SEL/MODE_RR encodings and WIDTH/NCH defaults.
REQ-030 Grant logic SHALL be a sub-module rr_arbiter (inputs req, last, mode, sel; output one-hot grant and index), purely combinational.
REQ-031 rr_mux holds only the output register and the last pointer.

Verification (WIDTH=5, NCH=4)
REQ-032 Reset then MODE_SEL, sel=2, ch2=5'b10101 valid, out_ready=1 -> next cycle out_valid=1, out_data=10101, out_sel=2; in_ready=4'b0100 in the request cycle.
REQ-033 MODE_RR, all four valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 MODE_RR, valid=4'b1010, last=1 -> grant ch3; then ch1; ch0/ch2 never granted.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 3 cycles with requests pending -> out_data stable, in_ready=0, last unchanged; out_ready=1 -> next word loads same edge.
REQ-036 MODE_SEL sel=2 with in_valid=4'b0000 -> out_valid falls to 0 after current word taken; out_data holds.
REQ-037 Assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately; after release, first RR grant goes to ch0.
